// File: rtl/alu_seq_ctrl_if.sv
// Command / result bundle between the host sequencer and alu_seq_ctrl.
// Optional macro ALU_SEQ_CTRL_ZFLAG_EN adds res_zero to the result side.
interface alu_seq_ctrl_if #(
    parameter int RA_W = 2,
    parameter int DW   = 8
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_ld;
    logic [3:0]      cmd_op;
    logic [RA_W-1:0] cmd_ra;
    logic [RA_W-1:0] cmd_rb;
    logic [RA_W-1:0] cmd_rd;
    logic [DW-1:0]   cmd_imm;

    logic            res_valid;
    logic [DW-1:0]   res_data;
    logic [RA_W-1:0] res_rd;
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
    logic            res_zero;
`endif

    // Host side: issues commands, consumes results.
    modport master (
        output cmd_valid, cmd_ld, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_imm,
        input  cmd_ready, res_valid, res_data, res_rd
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
        , input res_zero
`endif
    );

    // Controller side.
    modport slave (
        input  cmd_valid, cmd_ld, cmd_op, cmd_ra, cmd_rb, cmd_rd, cmd_imm,
        output cmd_ready, res_valid, res_data, res_rd
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
        , output res_zero
`endif
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Command sequencer for the 2-stage registered 8-bit ALU.
// Owns a 2**RA_W x DW register file, runs one command at a time:
// loads complete in one cycle, ALU ops take IDLE->ISSUE->WAIT->CAPT->IDLE.
// Optional macro ALU_SEQ_CTRL_ZFLAG_EN: registers a zero flag with each result.
module alu_seq_ctrl #(
    parameter int RA_W = 2,
    parameter int DW   = 8
) (
    input  logic            ck,
    input  logic            rst,
    alu_seq_ctrl_if.slave   bus,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    output logic [3:0]      alu_ctr,
    input  logic [DW-1:0]   alu_o,
    input  logic [RA_W-1:0] dbg_addr,
    output logic [DW-1:0]   dbg_data
);
    localparam int NREG = 2**RA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        CAPT  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [NREG-1:0][DW-1:0] rf_q;
    logic [DW-1:0]           alu_a_q, alu_b_q;
    logic [3:0]              alu_ctr_q;
    logic [RA_W-1:0]         rd_q;
    logic                    res_valid_q;
    logic [DW-1:0]           res_data_q;
    logic [RA_W-1:0]         res_rd_q;
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
    logic                    res_zero_q;
`endif

    logic accept, ld_acc, op_acc, wb;

    assign accept = bus.cmd_valid && bus.cmd_ready;
    assign ld_acc = accept &&  bus.cmd_ld;
    assign op_acc = accept && !bus.cmd_ld;
    // In CAPT the ALU result register already holds this op's result.
    assign wb     = (state_q == CAPT);

    // State register.
    always_ff @(posedge ck) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and ready; ready is masked by reset so nothing is accepted then.
    always_comb begin
        state_d       = state_q;
        bus.cmd_ready = 1'b0;
        case (state_q)
            IDLE: begin
                bus.cmd_ready = !rst;
                if (op_acc) state_d = ISSUE;
            end
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = CAPT;
            CAPT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Register file: write-back and load never coincide since loads need IDLE.
    always_ff @(posedge ck) begin
        if (rst)         rf_q <= '0;
        else if (wb)     rf_q[rd_q] <= alu_o;
        else if (ld_acc) rf_q[bus.cmd_rd] <= bus.cmd_imm;
    end

    // Operand capture at accept; held until the next ALU op so loads leave the ALU alone.
    always_ff @(posedge ck) begin
        if (rst) begin
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_ctr_q <= '0;
            rd_q      <= '0;
        end else if (op_acc) begin
            alu_a_q   <= rf_q[bus.cmd_ra];
            alu_b_q   <= rf_q[bus.cmd_rb];
            alu_ctr_q <= bus.cmd_op;
            rd_q      <= bus.cmd_rd;
        end
    end

    // Result report: one-cycle valid pulse, data/rd held until the next report.
    always_ff @(posedge ck) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
            res_zero_q  <= 1'b0;
`endif
        end else begin
            res_valid_q <= wb;
            if (wb) begin
                res_data_q <= alu_o;
                res_rd_q   <= rd_q;
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
                res_zero_q <= (alu_o == '0);
`endif
            end
        end
    end

    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_ctr       = alu_ctr_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_rd    = res_rd_q;
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
    assign bus.res_zero  = res_zero_q;
`endif
    assign dbg_data      = rf_q[dbg_addr];
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: behavioural 2-stage ALU, result scoreboard,
// one task per scenario.
module tb_alu_seq_ctrl;
    logic       ck = 1'b0;
    logic       rst;
    logic [7:0] alu_a, alu_b, alu_o;
    logic [3:0] alu_ctr;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] rd;
        logic [7:0] data;
        logic       zero;
    } exp_t;
    exp_t sb[$];

    logic [7:0] shadow [4];

    alu_seq_ctrl_if #(.RA_W(2), .DW(8)) bus ();

    alu_seq_ctrl #(.RA_W(2), .DW(8)) dut (
        .ck(ck), .rst(rst), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr), .alu_o(alu_o),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 ck = ~ck;

    // Behavioural ALU: stage 1 captures inputs, stage 2 registers the result.
    logic [7:0] a1, b1, o_q;
    logic [3:0] c1;
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
        case (c)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b1000: return a & b;
            4'b1001: return a | b;
            4'b1010: return a ^ b;
            4'b1011: return ~a;
            4'b1100: return {1'b0, a[7:1]};
            4'b1101: return {a[6:0], 1'b0};
            4'b1110: return {a[0], a[7:1]};
            4'b1111: return {a[6:0], a[7]};
            default: return 8'h00;
        endcase
    endfunction
    always @(posedge ck) begin
        a1  <= alu_a;
        b1  <= alu_b;
        c1  <= alu_ctr;
        o_q <= alu_f(a1, b1, c1);
    end
    assign alu_o = o_q;

    // Scoreboard consumer: every result pulse must match the oldest expectation.
    always @(negedge ck) begin
        if (rst === 1'b0 && bus.res_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_res_valid: got data=%h rd=%0d, required no result", bus.res_data, bus.res_rd);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.res_data !== e.data || bus.res_rd !== e.rd) begin
                    errors++;
                    $display("FAIL result: got data=%h rd=%0d, required data=%h rd=%0d", bus.res_data, bus.res_rd, e.data, e.rd);
                end
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
                checks++;
                if (bus.res_zero !== e.zero) begin
                    errors++;
                    $display("FAIL res_zero: got %b, required %b", bus.res_zero, e.zero);
                end
`endif
            end
        end
    end

    task automatic ld(input logic [1:0] rd, input logic [7:0] imm);
        @(posedge ck); #1;
        bus.cmd_valid = 1'b1; bus.cmd_ld = 1'b1; bus.cmd_rd = rd; bus.cmd_imm = imm;
        @(posedge ck); #1;
        bus.cmd_valid = 1'b0;
        shadow[rd] = imm;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [1:0] ra, input logic [1:0] rb,
                         input logic [1:0] rd, input logic [7:0] expv, input string nm);
        int n;
        exp_t e;
        @(posedge ck); #1;
        bus.cmd_valid = 1'b1; bus.cmd_ld = 1'b0; bus.cmd_op = op;
        bus.cmd_ra = ra; bus.cmd_rb = rb; bus.cmd_rd = rd;
        e.rd = rd; e.data = expv; e.zero = (expv == 8'h00);
        sb.push_back(e);
        @(posedge ck); #1;
        bus.cmd_valid = 1'b0;
        n = 0;
        do begin
            @(negedge ck); n++;
        end while (bus.res_valid !== 1'b1 && n < 8);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, required 4", nm, n);
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_after: got %b, required 1", nm, bus.cmd_ready);
        end
        shadow[rd] = expv;
        dbg_addr = rd; #1;
        checks++;
        if (dbg_data !== expv) begin
            errors++;
            $display("FAIL %s dbg: got %h, required %h", nm, dbg_data, expv);
        end
        @(negedge ck);
        checks++;
        if (bus.res_valid !== 1'b0 || bus.res_data !== expv) begin
            errors++;
            $display("FAIL %s pulse_hold: got valid=%b data=%h, required valid=0 data=%h", nm, bus.res_valid, bus.res_data, expv);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cmd_valid = 1'b1; bus.cmd_ld = 1'b1; bus.cmd_rd = 2'd0; bus.cmd_imm = 8'hAA;
        bus.cmd_op = 4'h0; bus.cmd_ra = 2'd0; bus.cmd_rb = 2'd0; dbg_addr = 2'd0;
        repeat (2) @(posedge ck);
        @(negedge ck);
        checks++;
        if (bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 0", bus.cmd_ready);
        end
        @(posedge ck); #1;
        rst = 1'b0; bus.cmd_valid = 1'b0;
        @(negedge ck);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.res_data !== 8'h00 ||
            bus.res_rd !== 2'd0 || alu_a !== 8'h00 || alu_b !== 8'h00 || alu_ctr !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b rv=%b rd=%h rrd=%0d a=%h b=%h ctr=%h, required 1 0 00 0 00 00 0",
                     bus.cmd_ready, bus.res_valid, bus.res_data, bus.res_rd, alu_a, alu_b, alu_ctr);
        end
`ifdef ALU_SEQ_CTRL_ZFLAG_EN
        checks++;
        if (bus.res_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_zero: got %b, required 0", bus.res_zero);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i); #1;
            checks++;
            if (dbg_data !== 8'h00) begin
                errors++;
                $display("FAIL reset_rf%0d: got %h, required 00", i, dbg_data);
            end
            shadow[i] = 8'h00;
        end
    endtask

    task automatic test_add();
        ld(2'd0, 8'h3C);
        ld(2'd1, 8'hC5);
        do_op(4'b0000, 2'd0, 2'd1, 2'd2, 8'h01, "add");
    endtask

    task automatic test_sub();
        do_op(4'b0001, 2'd0, 2'd1, 2'd3, 8'h77, "sub");
        do_op(4'b0001, 2'd3, 2'd3, 2'd3, 8'h00, "sub_self");
    endtask

    task automatic test_shift();
        do_op(4'b1111, 2'd1, 2'd0, 2'd0, 8'h8B, "rotl");
        do_op(4'b1110, 2'd1, 2'd0, 2'd0, 8'hE2, "rotr");
        do_op(4'b1100, 2'd1, 2'd0, 2'd0, 8'h62, "shr");
        do_op(4'b1101, 2'd1, 2'd0, 2'd0, 8'h8A, "shl");
    endtask

    // r0=8A, r1=C5: add -> 4F into r2, then sub -> C5 into r3, valid held high.
    task automatic test_back_to_back();
        exp_t e;
        @(posedge ck); #1;
        bus.cmd_valid = 1'b1; bus.cmd_ld = 1'b0; bus.cmd_op = 4'b0000;
        bus.cmd_ra = 2'd0; bus.cmd_rb = 2'd1; bus.cmd_rd = 2'd2;
        e.rd = 2'd2; e.data = 8'h4F; e.zero = 1'b0; sb.push_back(e);
        @(negedge ck);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_pre: got %b, required 1", bus.cmd_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge ck);
            checks++;
            if (bus.cmd_ready !== 1'b0 || alu_ctr !== 4'b0000 || bus.res_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_busy1_%0d: got rdy=%b ctr=%h rv=%b, required 0 0 0", i, bus.cmd_ready, alu_ctr, bus.res_valid);
            end
        end
        @(posedge ck); #1;
        bus.cmd_op = 4'b0001; bus.cmd_rd = 2'd3;
        e.rd = 2'd3; e.data = 8'hC5; e.zero = 1'b0; sb.push_back(e);
        @(negedge ck);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b1 || alu_ctr !== 4'b0000) begin
            errors++;
            $display("FAIL b2b_res1: got rdy=%b rv=%b ctr=%h, required 1 1 0", bus.cmd_ready, bus.res_valid, alu_ctr);
        end
        @(posedge ck); #1;
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge ck);
            else       @(negedge ck);
            checks++;
            if (bus.cmd_ready !== 1'b0 || alu_ctr !== 4'b0001) begin
                errors++;
                $display("FAIL b2b_busy2_%0d: got rdy=%b ctr=%h, required 0 1", i, bus.cmd_ready, alu_ctr);
            end
        end
        @(negedge ck);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_res2: got rdy=%b rv=%b, required 1 1", bus.cmd_ready, bus.res_valid);
        end
        shadow[2] = 8'h4F; shadow[3] = 8'hC5;
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i); #1;
            checks++;
            if (dbg_data !== shadow[i]) begin
                errors++;
                $display("FAIL b2b_rf%0d: got %h, required %h", i, dbg_data, shadow[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(posedge ck); #1;
        bus.cmd_valid = 1'b1; bus.cmd_ld = 1'b0; bus.cmd_op = 4'b0000;
        bus.cmd_ra = 2'd0; bus.cmd_rb = 2'd1; bus.cmd_rd = 2'd2;
        @(posedge ck); #1;
        bus.cmd_valid = 1'b0;
        @(posedge ck); #1;
        rst = 1'b1;
        @(negedge ck);
        checks++;
        if (bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_ready: got %b, required 0", bus.cmd_ready);
        end
        @(posedge ck); #1;
        rst = 1'b0;
        @(negedge ck);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0 || alu_ctr !== 4'h0 || bus.res_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_rst_after: got rdy=%b rv=%b ctr=%h rd=%h, required 1 0 0 00", bus.cmd_ready, bus.res_valid, alu_ctr, bus.res_data);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge ck);
            checks++;
            if (bus.res_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_rst_nores%0d: got %b, required 0", i, bus.res_valid);
            end
        end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i); #1;
            checks++;
            if (dbg_data !== 8'h00) begin
                errors++;
                $display("FAIL mid_rst_rf%0d: got %h, required 00", i, dbg_data);
            end
            shadow[i] = 8'h00;
        end
    endtask

    task automatic test_undef_and_loads();
        logic [7:0] imms [4];
        imms[0] = 8'hFF; imms[1] = 8'hFF; imms[2] = 8'h11; imms[3] = 8'h22;
        @(posedge ck); #1;
        bus.cmd_valid = 1'b1; bus.cmd_ld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.cmd_rd = 2'(i); bus.cmd_imm = imms[i];
            @(negedge ck);
            checks++;
            if (bus.cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL ld_ready%0d: got %b, required 1", i, bus.cmd_ready);
            end
            @(posedge ck); #1;
            shadow[i] = imms[i];
        end
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i); #1;
            checks++;
            if (dbg_data !== imms[i]) begin
                errors++;
                $display("FAIL ld_rf%0d: got %h, required %h", i, dbg_data, imms[i]);
            end
        end
        do_op(4'b0100, 2'd0, 2'd1, 2'd2, 8'h00, "undef");
        ld(2'd3, 8'h5A);
        @(negedge ck);
        checks++;
        if (alu_ctr !== 4'b0100 || alu_a !== 8'hFF || alu_b !== 8'hFF) begin
            errors++;
            $display("FAIL ld_no_alu: got ctr=%h a=%h b=%h, required 4 ff ff", alu_ctr, alu_a, alu_b);
        end
        dbg_addr = 2'd3; #1;
        checks++;
        if (dbg_data !== 8'h5A) begin
            errors++;
            $display("FAIL ld_r3: got %h, required 5a", dbg_data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_shift();
        test_back_to_back();
        test_reset_mid();
        test_undef_and_loads();
        repeat (3) @(negedge ck);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Command sequencer for the 8-bit registered ALU (2 register stages: operand/control capture, then result capture).
- Owns a small operand register file and accepts one command at a time over a valid/ready interface.
- Reads operands, drives the ALU's A/B/CTR inputs, waits out the ALU pipeline, writes the result back and reports it.
- Sits between the host/test sequencer and the ALU instance; the ALU shares clock ck.

Parameters:
RA_W, 2, register-address width; register count NREG = 2**RA_W (default 4 x 8-bit)
DW, 8, datapath width; fixed at 8 to match the ALU

Ports:
ck  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept; combinational = (state==IDLE) && !rst
cmd_ld  input  1  1 = load immediate, 0 = ALU op
cmd_op  input  4  ALU control code, passed to alu_ctr
cmd_ra  input  RA_W  source A register
cmd_rb  input  RA_W  source B register
cmd_rd  input  RA_W  destination register
cmd_imm  input  DW  immediate for cmd_ld
alu_a  output  DW  to ALU A (registered)
alu_b  output  DW  to ALU B (registered)
alu_ctr  output  4  to ALU CTR (registered)
alu_o  input  DW  from ALU O
res_valid  output  1  one-cycle pulse, ALU result written back
res_data  output  DW  result value, held until next res_valid
res_rd  output  RA_W  destination of reported result
dbg_addr  input  RA_W  debug read address
dbg_data  output  DW  combinational read of regfile[dbg_addr]

Behaviour:
- Reset (rst high at an edge):
  - state=IDLE; all regfile entries, alu_a, alu_b, alu_ctr, res_data and res_rd = 0; res_valid = 0.
  - cmd_ready = 0 in any cycle rst is high.
- Accept occurs at an edge where cmd_valid && cmd_ready.
- Load immediate (cmd_ld=1), accept edge:
  - regfile[cmd_rd] <= cmd_imm; state stays IDLE.
  - No res_valid, no ALU activity.
  - Back-to-back loads are allowed at 1 per cycle.
- ALU op (cmd_ld=0) FSM: IDLE -> ISSUE -> WAIT -> CAPT -> IDLE, one state per cycle.
  - Accept edge E0: alu_a <= regfile[cmd_ra], alu_b <= regfile[cmd_rb], alu_ctr <= cmd_op; latch cmd_rd; state <= ISSUE.
  - Edge E1: ALU captures its operands; state <= WAIT.
  - Edge E2: ALU captures its result; state <= CAPT.
  - Edge E3: regfile[rd] <= alu_o, res_data <= alu_o, res_rd <= rd, res_valid <= 1; state <= IDLE.
  - res_valid is high in the cycle after E3 only; cmd_ready is high again in that same cycle.
  - Throughput: one ALU op per 4 cycles.
- alu_a, alu_b and alu_ctr hold their values from E0 until the next ALU accept; no change on loads.
- Operands are read at the accept edge, so ra==rd or rb==rd uses the old value.
- A load accepted in the IDLE cycle after E3 sees the written-back value, since write-back precedes it.
- cmd_op is not checked. Undefined codes (0010–0111) are issued as-is and the result (0x00 from the ALU) is written back.
- Unary and shift ops (1011–1111) ignore B; rb is still read and driven.
- Arithmetic is modulo 2^8, no carry/borrow reported.
- Reset mid-operation (any non-IDLE state): op aborted, no write-back, no res_valid, regfile cleared.
- Inputs during reset are ignored.

Optional Feature:
ALU_SEQ_CTRL_ZFLAG_EN
- Defined: adds output res_zero (1 bit).
  - Registered at E3 as (alu_o == 0), so it is valid alongside res_valid and held until the next ALU op.
  - Reset value 0; loads do not affect it.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. Reset, ld r0=0x3C, ld r1=0xC5, op 0000 ra=0 rb=1 rd=2 -> res_valid exactly 4 edges after accept (E3+), res_data=0x01, res_rd=2, dbg r2=0x01.
2. Same regs, op 0001 ra=0 rb=1 rd=3 -> res_data=0x77. Then op 0001 ra=3 rb=3 rd=3 -> 0x00, and res_zero=1 with ZFLAG_EN.
3. r1=0xC5: op 1111 ra=1 rd=0 -> 0x8B; op 1110 ra=1 rd=0 -> 0xE2; op 1100 -> 0x62; op 1101 -> 0x8A.
4. cmd_valid held high across two ALU ops -> cmd_ready low for exactly 3 cycles after each accept; second accept lands in the res_valid cycle; alu_ctr stable throughout.
5. Assert rst for 1 cycle while in WAIT -> no res_valid; dbg_data=0 for all regs; cmd_ready high in the cycle after rst drops.
6. Undefined op 0100 with r0=0xFF, r1=0xFF -> res_data=0x00 written to rd; four consecutive loads accepted on four consecutive edges.
